// File: rtl/keccak_pkg.sv
// -----------------------------------------------------------------------------
// keccak_pkg
// Shared definitions for the Keccak/SHA-3 padder: the widest rate, the
// run-time rate select encoding and its table in bits, the padding byte
// constants, and the padder state encoding.
// -----------------------------------------------------------------------------
package keccak_pkg;

    // Widest supported rate (SHA3-224); the output block is always this wide.
    localparam int MAX_RATE = 1152;

    // Run-time rate select, named by rate in bits.
    typedef enum logic [1:0] {
        RATE_1152 = 2'b00,  // 224-bit digest
        RATE_1088 = 2'b01,  // 256-bit digest
        RATE_832  = 2'b10,  // 384-bit digest
        RATE_576  = 2'b11   // 512-bit digest
    } rate_sel_e;

    // Padding bytes: domain byte for original Keccak / FIPS 202 SHA-3, and the
    // closing bit of multi-rate padding in the last byte of the final block.
    localparam logic [7:0] PAD_KECCAK = 8'h01;
    localparam logic [7:0] PAD_SHA3   = 8'h06;
    localparam logic [7:0] PAD_FINAL  = 8'h80;

    typedef enum logic [1:0] {
        ST_ACCEPT,  // taking message words
        ST_PAD,     // inserting zero words after the last message word
        ST_FULL,    // block complete, waiting for the consumer
        ST_DONE     // final block delivered, idle until reset
    } state_e;

    // Per-mode rate table, in bits.
    function automatic int rate_bits(rate_sel_e sel);
        case (sel)
            RATE_1152: return 1152;
            RATE_1088: return 1088;
            RATE_832:  return 832;
            default:   return 576;
        endcase
    endfunction

    // Mask covering the rate region out[R-1:0] of a MAX_RATE-wide block.
    function automatic logic [MAX_RATE-1:0] rate_mask(rate_sel_e sel);
        return ~({MAX_RATE{1'b1}} << rate_bits(sel));
    endfunction

endpackage

// File: rtl/keccak_padder_p_if.sv
// -----------------------------------------------------------------------------
// keccak_padder_p_if
// Producer/consumer bundle of the Keccak padder.
//   in, in_ready, is_last, byte_num, mode : message word stream (producer)
//   f_ack                                  : consumer took the block
//   buffer_full, out, out_ready            : assembled block (padder)
// Modports: master = producer/consumer side, slave = padder side.
// -----------------------------------------------------------------------------
interface keccak_padder_p_if #(
    parameter int W = 32
);
    logic [W-1:0]                   in;
    logic                           in_ready;
    logic                           is_last;
    logic [$clog2(W/8)-1:0]         byte_num;
    logic [1:0]                     mode;
    logic                           f_ack;
    logic                           buffer_full;
    logic [keccak_pkg::MAX_RATE-1:0] out;
    logic                           out_ready;

    modport master (
        output in, in_ready, is_last, byte_num, mode, f_ack,
        input  buffer_full, out, out_ready
    );

    modport slave (
        input  in, in_ready, is_last, byte_num, mode, f_ack,
        output buffer_full, out, out_ready
    );
endinterface

// File: rtl/keccak_pad_word.sv
// -----------------------------------------------------------------------------
// keccak_pad_word
// Combinational word padder. A non-last word passes through unchanged. For the
// last word, the top byte_num bytes (counted from the MSB end) are kept, the
// next byte becomes the pad byte and every byte below it is cleared.
// Ports:
//   in_i       W-bit message word, first byte in the MSBs
//   byte_num_i valid bytes in the last word, 0..W/8-1
//   is_last_i  the word is the final message word
//   pad_byte_i domain pad byte
//   w_o        word to shift into the block
// -----------------------------------------------------------------------------
module keccak_pad_word #(
    parameter int W = 32
) (
    input  logic [W-1:0]           in_i,
    input  logic [$clog2(W/8)-1:0] byte_num_i,
    input  logic                   is_last_i,
    input  logic [7:0]             pad_byte_i,
    output logic [W-1:0]           w_o
);

    always_comb begin
        // NOTE: every output of a combinational block gets a value before any
        // branch, so no path leaves it unassigned and no latch is inferred.
        w_o = in_i;
        if (is_last_i) begin
            for (int i = 0; i < W/8; i++) begin
                if (i < int'(byte_num_i)) begin
                    w_o[W-1-8*i -: 8] = in_i[W-1-8*i -: 8];
                end else if (i == int'(byte_num_i)) begin
                    w_o[W-1-8*i -: 8] = pad_byte_i;
                end else begin
                    w_o[W-1-8*i -: 8] = 8'h00;
                end
            end
        end
    end

endmodule

// File: rtl/keccak_padder_p.sv
// -----------------------------------------------------------------------------
// keccak_padder_p
// Message padder and block assembler for the Keccak/SHA-3 permutation. Packs
// W-bit words into one rate-sized block (rate selected at run time, latched
// on the first accepted word after reset), applies multi-rate padding and
// presents each block until the consumer acknowledges it.
// Parameters:
//   W      input word width, 32 or 64
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous reset, active-low
//   bus    keccak_padder_p_if slave: word stream in, block and handshake out
// Configuration macro:
//   SHA3_DOMAIN_PAD_EN  defined: pad byte 0x06 (SHA-3); undefined: 0x01 (Keccak)
// -----------------------------------------------------------------------------
module keccak_padder_p
    import keccak_pkg::*;
#(
    parameter int W = 32
) (
    input logic               clk,
    input logic               reset,
    keccak_padder_p_if.slave  bus
);

    localparam int CW = 6;  // holds RW up to 36

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                final_q, final_d;
    logic [MAX_RATE-1:0] out_q, out_d;
    rate_sel_e           mode_q, mode_d;
    logic                mode_vld_q, mode_vld_d;
    logic                full_q, full_d;

    rate_sel_e           mode_eff;
    logic [CW-1:0]       rw;
    logic [CW-1:0]       cnt_inc;
    logic [7:0]          pad_byte;
    logic [W-1:0]        pad_w;
    logic                shift_en;
    logic [W-1:0]        shift_word;
    logic                mark_final;

`ifdef SHA3_DOMAIN_PAD_EN
    assign pad_byte = PAD_SHA3;
`else
    assign pad_byte = PAD_KECCAK;
`endif

    keccak_pad_word #(.W(W)) u_pad_word (
        .in_i       (bus.in),
        .byte_num_i (bus.byte_num),
        .is_last_i  (bus.is_last),
        .pad_byte_i (pad_byte),
        .w_o        (pad_w)
    );

    // Before the first word is taken the live mode decides the rate, so the
    // very first word is already counted against the rate it latches.
    assign mode_eff = mode_vld_q ? mode_q : rate_sel_e'(bus.mode);
    assign rw       = CW'(rate_bits(mode_eff) / W);
    assign cnt_inc  = cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        final_d    = final_q;
        mode_d     = mode_q;
        mode_vld_d = mode_vld_q;
        shift_en   = 1'b0;
        shift_word = '0;
        mark_final = 1'b0;

        case (state_q)
            ST_ACCEPT: begin
                if (bus.in_ready && !full_q) begin
                    shift_en   = 1'b1;
                    shift_word = pad_w;
                    cnt_d      = cnt_inc;
                    if (!mode_vld_q) begin
                        mode_d     = mode_eff;
                        mode_vld_d = 1'b1;
                    end
                    if (cnt_inc == rw) begin
                        state_d    = ST_FULL;
                        final_d    = bus.is_last;
                        mark_final = bus.is_last;
                    end else if (bus.is_last) begin
                        state_d = ST_PAD;
                        final_d = 1'b1;
                    end
                end
            end
            ST_PAD: begin
                // One zero word per cycle until the block holds RW words.
                shift_en = 1'b1;
                cnt_d    = cnt_inc;
                if (cnt_inc == rw) begin
                    state_d    = ST_FULL;
                    mark_final = final_q;
                end
            end
            ST_FULL: begin
                // in_ready is not looked at here: a word offered together with
                // f_ack stays with the producer and lands in slot 0 next edge.
                if (bus.f_ack) begin
                    cnt_d   = '0;
                    state_d = final_q ? ST_DONE : ST_ACCEPT;
                end
            end
            ST_DONE: ;
            default: state_d = ST_ACCEPT;
        endcase

        out_d = out_q;
        if (shift_en) begin
            // Bits pushed past the rate boundary are masked, keeping out[R+:]
            // zero whatever the previous block left there.
            out_d = ((out_q << W) | MAX_RATE'(shift_word)) & rate_mask(mode_eff);
            if (mark_final) begin
                out_d = out_d | MAX_RATE'(PAD_FINAL);
            end
        end

        full_d = (state_d == ST_FULL);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_ACCEPT;
            cnt_q      <= '0;
            final_q    <= 1'b0;
            // NOTE: the block register is reset on purpose: out is a visible
            // output whose value after reset must read as zero.
            out_q      <= '0;
            mode_q     <= RATE_1152;
            mode_vld_q <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            final_q    <= final_d;
            out_q      <= out_d;
            mode_q     <= mode_d;
            mode_vld_q <= mode_vld_d;
            full_q     <= full_d;
        end
    end

    // out_ready and buffer_full are high exactly in FULL, so one flop feeds both.
    assign bus.out         = out_q;
    assign bus.out_ready   = full_q;
    assign bus.buffer_full = full_q;

endmodule

// File: tb/tb_keccak_padder_p.sv
// -----------------------------------------------------------------------------
// tb_keccak_padder_p
// Self-checking bench for keccak_padder_p at W=32 and W=64. Messages are byte
// queues; the reference pads them at byte level (message, pad byte, zeros,
// 0x80 into the last byte) and cuts rate-sized blocks, then compares every
// presented block, the pad latency, the slot-0 word, backpressure and DONE.
// -----------------------------------------------------------------------------
module tb_keccak_padder_p;

    localparam int MAXR = 1152;

`ifdef SHA3_DOMAIN_PAD_EN
    localparam logic [7:0] PAD_BYTE = 8'h06;
`else
    localparam logic [7:0] PAD_BYTE = 8'h01;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    logic        sel64 = 1'b0;
    logic [63:0] drv_in = '0;
    logic        drv_valid = 1'b0;
    logic        drv_last = 1'b0;
    logic [2:0]  drv_bn = '0;
    logic [1:0]  drv_mode = '0;
    logic        drv_ack = 1'b0;

    logic [MAXR-1:0] obs_out;
    logic            obs_ready;
    logic            obs_bf;

    logic [7:0]      msg_q[$];
    logic [MAXR-1:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    keccak_padder_p_if #(.W(32)) if32 ();
    keccak_padder_p_if #(.W(64)) if64 ();

    keccak_padder_p #(.W(32)) dut32 (.clk(clk), .reset(reset), .bus(if32.slave));
    keccak_padder_p #(.W(64)) dut64 (.clk(clk), .reset(reset), .bus(if64.slave));

    assign if32.in       = drv_in[31:0];
    assign if32.in_ready = drv_valid & ~sel64;
    assign if32.is_last  = drv_last;
    assign if32.byte_num = drv_bn[1:0];
    assign if32.mode     = drv_mode;
    assign if32.f_ack    = drv_ack & ~sel64;

    assign if64.in       = drv_in;
    assign if64.in_ready = drv_valid & sel64;
    assign if64.is_last  = drv_last;
    assign if64.byte_num = drv_bn;
    assign if64.mode     = drv_mode;
    assign if64.f_ack    = drv_ack & sel64;

    assign obs_out   = sel64 ? if64.out : if32.out;
    assign obs_ready = sel64 ? if64.out_ready : if32.out_ready;
    assign obs_bf    = sel64 ? if64.buffer_full : if32.buffer_full;

    // Reports the lowest differing 64-bit slice so lines stay short.
    task automatic check(input string tag, input logic [MAXR-1:0] got, input logic [MAXR-1:0] exp);
        int c;
        n_vec++;
        if (got !== exp) begin
            c = 0;
            for (int i = MAXR/64 - 1; i >= 0; i--)
                if (got[i*64 +: 64] !== exp[i*64 +: 64]) c = i;
            n_err++;
            $display("FAIL %s: bits[%0d+:64] got %h expected %h",
                     tag, c*64, got[c*64 +: 64], exp[c*64 +: 64]);
        end
    endtask

    function automatic int rate_of(input logic [1:0] md);
        case (md)
            2'd0:    return 1152;
            2'd1:    return 1088;
            2'd2:    return 832;
            default: return 576;
        endcase
    endfunction

    task automatic set_rand(input int n);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
    endtask

    task automatic set_str(input string s);
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    endtask

    // Byte-level multi-rate padding of msg_q into rate blocks, right-aligned.
    task automatic build_expected(input int rbits);
        logic [7:0]      p[$];
        logic [MAXR-1:0] blk;
        int              rb;
        rb = rbits / 8;
        p = msg_q;
        p.push_back(PAD_BYTE);
        while (p.size() % rb != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] | 8'h80;
        exp_q.delete();
        for (int b = 0; b < p.size() / rb; b++) begin
            blk = '0;
            for (int i = 0; i < rb; i++) blk[rbits-1-8*i -: 8] = p[b*rb + i];
            exp_q.push_back(blk);
        end
    endtask

    task automatic do_reset();
        drv_valid = 1'b0;
        drv_ack   = 1'b0;
        drv_last  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("rst_out", obs_out, '0);
        check("rst_flags", MAXR'({obs_ready, obs_bf}), '0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Sends msg_q as words at rate md; acks each block after ack_min..ack_max
    // held cycles; mode is randomised after the first accepted word.
    task automatic run_msg(input logic [1:0] md, input int ack_min, input int ack_max);
        int          wb, wbits, rbits, rw, nwords, wi, blk, hold, budget, lat_exp, last_cyc;
        logic [63:0] words[$];
        logic [63:0] w, wmask, prev_word;
        logic        took_prev, prev_last, locked, shown;
        wb      = sel64 ? 8 : 4;
        wbits   = wb * 8;
        wmask   = sel64 ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
        rbits   = rate_of(md);
        rw      = rbits / wbits;
        nwords  = msg_q.size() / wb + 1;
        for (int i = 0; i < nwords; i++) begin
            w = '0;
            for (int j = 0; j < wb; j++)
                w[wbits-1-8*j -: 8] = (i*wb + j < msg_q.size()) ? msg_q[i*wb + j] : 8'($urandom);
            words.push_back(w);
        end
        lat_exp = rw - 1 - ((nwords - 1) % rw);
        build_expected(rbits);

        wi = 0; blk = 0; hold = 0; budget = 4000; last_cyc = 0;
        took_prev = 1'b0; prev_last = 1'b0; prev_word = '0; locked = 1'b0; shown = 1'b0;
        drv_ack = 1'b0; drv_valid = 1'b0;
        while (blk < exp_q.size()) begin
            @(negedge clk);
            if (budget == 0) begin
                check("timeout_blocks", MAXR'(blk), MAXR'(exp_q.size()));
                break;
            end
            budget--;
            if (took_prev) begin
                if (prev_last) last_cyc = cyc;
                else check("slot0_word", MAXR'(obs_out[63:0] & wmask), MAXR'(prev_word));
            end
            if (obs_ready && !shown) begin
                check("block", obs_out, exp_q[blk]);
                if (blk == exp_q.size() - 1)
                    check("pad_latency", MAXR'(cyc - last_cyc), MAXR'(lat_exp));
                shown = 1'b1;
                hold  = $urandom_range(ack_max, ack_min);
            end
            if (shown) check("full_flags", MAXR'({obs_ready, obs_bf}), MAXR'(2'b11));

            took_prev = 1'b0;
            if (shown && hold == 0) begin
                drv_ack = 1'b1;
                shown   = 1'b0;
                blk++;
            end else begin
                drv_ack = shown ? 1'b0 : 1'($urandom);
                if (shown) hold--;
            end
            if (wi < nwords) begin
                drv_valid = 1'b1;
                drv_in    = words[wi];
                drv_last  = (wi == nwords - 1);
                drv_bn    = drv_last ? 3'(msg_q.size() % wb) : 3'($urandom);
                if (!obs_bf) begin
                    took_prev = 1'b1;
                    prev_last = drv_last;
                    prev_word = words[wi];
                    wi++;
                end
            end else begin
                drv_valid = 1'b0;
                drv_in    = {$urandom, $urandom};
                drv_last  = 1'($urandom);
            end
            drv_mode = locked ? 2'($urandom) : md;
            if (took_prev) locked = 1'b1;
        end

        // DONE: inputs ignored, last block kept, handshake low.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("done_flags", MAXR'({obs_ready, obs_bf}), '0);
            check("done_hold", obs_out, exp_q[$]);
            drv_valid = 1'b1;
            drv_in    = {$urandom, $urandom};
            drv_last  = 1'($urandom);
            drv_ack   = 1'($urandom);
        end
        drv_valid = 1'b0;
        drv_ack   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        do_reset();
        set_str("Hello, world!"); run_msg(2'd3, 0, 0);   // pad after slot 3, 14 PAD cycles
        do_reset(); set_rand(71);  run_msg(2'd3, 0, 2);  // 0x81 in last byte, no PAD
        do_reset(); set_rand(80);  run_msg(2'd3, 5, 5);  // backpressure with held word
        do_reset(); set_rand(10);  run_msg(2'd1, 0, 1);  // RW=34, upper bits zero
        do_reset(); set_rand(72);  run_msg(2'd3, 0, 1);  // exact multiple at 576
        do_reset(); set_rand(144); run_msg(2'd0, 0, 1);  // exact multiple at 1152
        do_reset(); msg_q.delete(); run_msg(2'd3, 0, 0); // empty message

        // Asynchronous reset between edges after 5 accepted words.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drv_valid = 1'b1;
            drv_in    = {$urandom, $urandom};
            drv_last  = 1'b0;
            drv_mode  = 2'd3;
        end
        @(negedge clk);
        drv_valid = 1'b0;
        check("pre_rst_loaded", MAXR'(obs_out != '0), MAXR'(1));
        #2 reset = 1'b0;
        #1;
        check("async_rst_out", obs_out, '0);
        check("async_rst_flags", MAXR'({obs_ready, obs_bf}), '0);
        @(negedge clk);
        reset = 1'b1;
        set_rand(33); run_msg(2'd2, 0, 2);

        for (int n = 0; n < 8; n++) begin
            do_reset();
            set_rand($urandom_range(0, 300));
            run_msg(2'($urandom), 0, 4);
        end

        sel64 = 1'b1;
        do_reset(); set_rand(70); run_msg(2'd3, 0, 1);   // 9 slots, last in slot 8
        do_reset(); msg_q.delete(); run_msg(2'd3, 0, 0);
        for (int n = 0; n < 3; n++) begin
            do_reset();
            set_rand($urandom_range(0, 300));
            run_msg(2'($urandom), 0, 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
